axis_frame_reader: RTL and testbench

- AXI-Stream memory endpoint and read-back engine; the counterpart that receives what the memory controller's master port writes.
- Stores incoming beats, framed by tlast, in an internal word buffer.
- Replays each complete (committed) frame, in order, on an AXI-Stream master port for downstream consumers.
- Sits between the memory controller's m01 port and any stream consumer.

---
 rtl/axis_frame_reader_pkg.sv | 29 ++
 rtl/axis_frame_reader_if.sv | 28 ++
 rtl/frame_buffer_ram.sv | 25 ++
 rtl/axis_frame_reader.sv | 170 +++++++++++++++++
 tb/tb_axis_frame_reader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/axis_frame_reader_pkg.sv
// Shared types for the AXI-Stream frame buffer: FSM state encodings and the
// layout of one buffered word.
package axis_frame_pkg;

    typedef enum logic {
        W_ACCEPT = 1'b0,
        W_DROP   = 1'b1
    } w_state_t;

    typedef enum logic {
        M_IDLE   = 1'b0,
        M_STREAM = 1'b1
    } m_state_t;

    localparam int FRAME_DATA_WIDTH = 32;

    // One buffer word at the default width; the RAM keeps these fields packed
    // in the same order {last, strb, data} for any DATA_WIDTH.
    typedef struct packed {
        logic                            last;
        logic [FRAME_DATA_WIDTH/8-1:0]   strb;
        logic [FRAME_DATA_WIDTH-1:0]     data;
    } frame_entry_t;

    function automatic int entry_width(input int data_width);
        return data_width + data_width / 8 + 1;
    endfunction

endpackage

// File: rtl/axis_frame_reader_if.sv
// AXI-Stream channel bundle; master drives payload/valid, slave drives ready.
interface axis_frame_reader_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata,
        output tstrb,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/frame_buffer_ram.sv
// Frame word store: synchronous write port, combinational read port, no reset.
module frame_buffer_ram #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_frame_reader.sv
// Buffers tlast-framed AXI-Stream beats and replays each committed frame in
// order; frames that cannot fit in the empty buffer are dropped and flagged.
//
// state    | meaning
// W_ACCEPT | storing beats of the current frame
// W_DROP   | discarding the rest of an oversized frame up to its tlast
// M_IDLE   | waiting for a committed frame
// M_STREAM | presenting words of the current frame on m00
module axis_frame_reader
    import axis_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    axis_frame_reader_if.slave    s00_axis,
    axis_frame_reader_if.master   m00_axis,
    output logic [ADDR_WIDTH:0]   frame_count,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int ENTRY_WIDTH = entry_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    w_state_t w_state;
    m_state_t m_state;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] frame_start;
    logic [ADDR_WIDTH:0]   word_count;
    logic [ADDR_WIDTH:0]   part_len;
    logic                  commit_pend;

    logic                   s_hs;
    logic                   null_beat;
    logic                   store;
    logic                   commit;
    logic                   full_drop;
    logic                   m_hs;
    logic                   release_frame;
    logic [ENTRY_WIDTH-1:0] wr_entry;
    logic [ENTRY_WIDTH-1:0] rd_entry;

    // Ready is forced low while reset is held, independent of the counters.
    assign s00_axis.tready = axis_aresetn &&
                             ((w_state == W_DROP) || (word_count < DEPTH_CNT));

    assign s_hs      = s00_axis.tvalid && s00_axis.tready;
    assign null_beat = (s00_axis.tstrb == '0) && !s00_axis.tlast;
    assign store     = (w_state == W_ACCEPT) && s_hs && !null_beat;
    assign commit    = store && s00_axis.tlast;

    // Buffer full of nothing but the open frame: it can never be drained.
    assign full_drop = (w_state == W_ACCEPT) && (word_count == DEPTH_CNT) &&
                       (frame_count == '0) && (part_len != '0);

    assign m_hs          = (m_state == M_STREAM) && m00_axis.tvalid && m00_axis.tready;
    assign release_frame = m_hs && m00_axis.tlast;

    assign wr_entry = {s00_axis.tlast, s00_axis.tstrb, s00_axis.tdata};

    frame_buffer_ram #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (axis_aclk),
        .wr_en   (store),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            w_state     <= W_ACCEPT;
            wr_ptr      <= '0;
            frame_start <= '0;
            part_len    <= '0;
            commit_pend <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            commit_pend <= commit;
            if (full_drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            case (w_state)
                W_ACCEPT: begin
                    if (full_drop) begin
                        wr_ptr   <= frame_start;
                        part_len <= '0;
                        w_state  <= W_DROP;
                    end else if (store) begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                        if (s00_axis.tlast) begin
                            frame_start <= wr_ptr + PTR_ONE;
                            part_len    <= '0;
                        end else begin
                            part_len <= part_len + CNT_ONE;
                        end
                    end
                end
                W_DROP: begin
                    if (s_hs && s00_axis.tlast) begin
                        w_state <= W_ACCEPT;
                    end
                end
                default: w_state <= W_ACCEPT;
            endcase
        end
    end

    // A word stays counted until its output handshake, so the slot held in
    // the output register is never reclaimed early.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            word_count  <= '0;
            frame_count <= '0;
        end else begin
            word_count  <= word_count + (ADDR_WIDTH + 1)'(store)
                           - (ADDR_WIDTH + 1)'(m_hs)
                           - (full_drop ? part_len : '0);
            frame_count <= frame_count + (ADDR_WIDTH + 1)'(commit_pend)
                           - (ADDR_WIDTH + 1)'(release_frame);
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m_state         <= M_IDLE;
            rd_ptr          <= '0;
            m00_axis.tdata  <= '0;
            m00_axis.tstrb  <= '0;
            m00_axis.tlast  <= 1'b0;
            m00_axis.tvalid <= 1'b0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (frame_count != '0) begin
                        {m00_axis.tlast, m00_axis.tstrb, m00_axis.tdata} <= rd_entry;
                        m00_axis.tvalid <= 1'b1;
                        rd_ptr          <= rd_ptr + PTR_ONE;
                        m_state         <= M_STREAM;
                    end
                end
                M_STREAM: begin
                    if (m_hs) begin
                        if (m00_axis.tlast) begin
                            m00_axis.tvalid <= 1'b0;
                            m_state         <= M_IDLE;
                        end else begin
                            {m00_axis.tlast, m00_axis.tstrb, m00_axis.tdata} <= rd_entry;
                            rd_ptr <= rd_ptr + PTR_ONE;
                        end
                    end
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_reader.sv
// Directed bench for axis_frame_reader at DEPTH = 4: reset, framing, stall,
// null beats, overflow drop, full-buffer backpressure and mid-frame reset.
module tb_axis_frame_reader;
    import axis_frame_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          axis_aclk = 1'b0;
    logic          axis_aresetn;
    logic          clr_overflow;
    logic [AW:0]   frame_count;
    logic          overflow;

    axis_frame_reader_if #(.DATA_WIDTH(DW)) s00_axis ();
    axis_frame_reader_if #(.DATA_WIDTH(DW)) m00_axis ();

    axis_frame_reader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .axis_aclk    (axis_aclk),
        .axis_aresetn (axis_aresetn),
        .s00_axis     (s00_axis),
        .m00_axis     (m00_axis),
        .frame_count  (frame_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 axis_aclk = ~axis_aclk;

    int n_cmp = 0;
    int n_bad = 0;
    frame_entry_t rx_q[$];

    // Output beats are captured mid-low-phase, where inputs and registers are settled.
    always @(negedge axis_aclk) begin
        frame_entry_t e;
        #2;
        if (axis_aresetn && m00_axis.tvalid && m00_axis.tready) begin
            e = {m00_axis.tlast, m00_axis.tstrb, m00_axis.tdata};
            rx_q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int k = 0;
        @(negedge axis_aclk);
        s00_axis.tdata  = d;
        s00_axis.tstrb  = s;
        s00_axis.tlast  = l;
        s00_axis.tvalid = 1'b1;
        while (!s00_axis.tready && k < 50) begin
            @(negedge axis_aclk);
            k++;
        end
        chk("send_ready_wait", 64'(k < 50), 64'd1);
        @(posedge axis_aclk);
    endtask

    task automatic idle_s();
        @(negedge axis_aclk);
        s00_axis.tvalid = 1'b0;
        s00_axis.tlast  = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n);
        int k = 0;
        while (rx_q.size() < n && k < 200) begin
            @(negedge axis_aclk);
            k++;
        end
        chk(tag, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic [3:0] s, input logic l);
        frame_entry_t e;
        frame_entry_t x;
        x = {l, s, d};
        if (rx_q.size() > 0) e = rx_q.pop_front();
        else e = 'x;
        chk(tag, 64'(e), 64'(x));
    endtask

    initial begin
        axis_aresetn     = 1'b1;
        clr_overflow     = 1'b0;
        s00_axis.tdata   = '0;
        s00_axis.tstrb   = '0;
        s00_axis.tlast   = 1'b0;
        s00_axis.tvalid  = 1'b0;
        m00_axis.tready  = 1'b0;
        #1 axis_aresetn  = 1'b0;

        // reset held for three cycles
        repeat (3) @(negedge axis_aclk);
        chk("rst_m_tvalid", 64'(m00_axis.tvalid), 64'd0);
        chk("rst_m_tdata",  64'(m00_axis.tdata),  64'd0);
        chk("rst_m_tstrb",  64'(m00_axis.tstrb),  64'd0);
        chk("rst_m_tlast",  64'(m00_axis.tlast),  64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_s_tready", 64'(s00_axis.tready), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        axis_aresetn = 1'b1;
        @(negedge axis_aclk);
        chk("post_rst_s_tready", 64'(s00_axis.tready), 64'd1);

        // basic frame with the consumer stalled
        send_beat(32'h11, 4'hF, 1'b0);
        send_beat(32'h22, 4'hF, 1'b0);
        send_beat(32'h33, 4'hF, 1'b1);
        idle_s();
        chk("fc_at_commit_edge", 64'(frame_count), 64'd0);
        @(negedge axis_aclk);
        chk("fc_commit_plus1", 64'(frame_count), 64'd1);
        chk("tvalid_commit_plus1", 64'(m00_axis.tvalid), 64'd0);
        @(negedge axis_aclk);
        chk("tvalid_commit_plus2", 64'(m00_axis.tvalid), 64'd1);
        chk("first_word", 64'(m00_axis.tdata), 64'h11);
        for (int i = 0; i < 10; i++) begin
            @(negedge axis_aclk);
            chk("stall_hold", {31'd0, m00_axis.tvalid, m00_axis.tdata}, {31'd0, 1'b1, 32'h11});
        end
        m00_axis.tready = 1'b1;
        wait_rx("basic_rx_count", 3);
        chk_beat("basic_b0", 32'h11, 4'hF, 1'b0);
        chk_beat("basic_b1", 32'h22, 4'hF, 1'b0);
        chk_beat("basic_b2", 32'h33, 4'hF, 1'b1);
        @(negedge axis_aclk);
        chk("basic_fc_done", 64'(frame_count), 64'd0);
        chk("basic_tvalid_done", 64'(m00_axis.tvalid), 64'd0);

        // null beats: strb 0 without tlast vanishes, strb 0 with tlast is a frame
        send_beat(32'hA1, 4'hF, 1'b0);
        send_beat(32'hDEAD, 4'h0, 1'b0);
        send_beat(32'hA2, 4'hF, 1'b1);
        send_beat(32'h5A, 4'h0, 1'b1);
        idle_s();
        wait_rx("null_rx_count", 3);
        chk_beat("null_b0", 32'hA1, 4'hF, 1'b0);
        chk_beat("null_b1", 32'hA2, 4'hF, 1'b1);
        chk_beat("null_b2", 32'h5A, 4'h0, 1'b1);

        // six-beat frame into a four-word buffer
        for (int i = 0; i < 6; i++) begin
            send_beat(32'hE0 + 32'(i), 4'hF, (i == 5));
        end
        idle_s();
        repeat (4) @(negedge axis_aclk);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_fc", 64'(frame_count), 64'd0);
        chk("ovf_no_output", 64'(rx_q.size()), 64'd0);
        send_beat(32'hB0, 4'hF, 1'b0);
        send_beat(32'hB1, 4'hF, 1'b1);
        idle_s();
        wait_rx("ovf_next_rx_count", 2);
        chk_beat("ovf_next_b0", 32'hB0, 4'hF, 1'b0);
        chk_beat("ovf_next_b1", 32'hB1, 4'hF, 1'b1);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        clr_overflow = 1'b1;
        @(negedge axis_aclk);
        clr_overflow = 1'b0;
        chk("ovf_cleared", 64'(overflow), 64'd0);

        // full buffer holding a committed frame: backpressure, then drain
        m00_axis.tready = 1'b0;
        send_beat(32'hC0, 4'hF, 1'b0);
        send_beat(32'hC1, 4'hF, 1'b0);
        send_beat(32'hC2, 4'hF, 1'b1);
        send_beat(32'hD0, 4'hF, 1'b0);
        @(negedge axis_aclk);
        s00_axis.tdata  = 32'hD1;
        s00_axis.tstrb  = 4'hF;
        s00_axis.tlast  = 1'b1;
        s00_axis.tvalid = 1'b1;
        chk("full_tready_low", 64'(s00_axis.tready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge axis_aclk);
            chk("full_tready_hold", 64'(s00_axis.tready), 64'd0);
        end
        chk("full_out_valid", 64'(m00_axis.tvalid), 64'd1);
        chk("full_out_word", 64'(m00_axis.tdata), 64'hC0);
        m00_axis.tready = 1'b1;
        @(negedge axis_aclk);
        chk("full_fc_after_read", 64'(frame_count), 64'd1);
        chk("full_tready_back", 64'(s00_axis.tready), 64'd1);
        @(negedge axis_aclk);
        s00_axis.tvalid = 1'b0;
        s00_axis.tlast  = 1'b0;
        chk("full_fc_at_commit", 64'(frame_count), 64'd1);
        @(negedge axis_aclk);
        chk("fc_commit_and_release", 64'(frame_count), 64'd1);
        wait_rx("full_rx_count", 5);
        chk_beat("full_c0", 32'hC0, 4'hF, 1'b0);
        chk_beat("full_c1", 32'hC1, 4'hF, 1'b0);
        chk_beat("full_c2", 32'hC2, 4'hF, 1'b1);
        chk_beat("full_d0", 32'hD0, 4'hF, 1'b0);
        chk_beat("full_d1", 32'hD1, 4'hF, 1'b1);
        @(negedge axis_aclk);
        chk("full_fc_done", 64'(frame_count), 64'd0);

        // reset while a committed frame is being presented
        m00_axis.tready = 1'b0;
        send_beat(32'hF0, 4'hF, 1'b0);
        send_beat(32'hF1, 4'hF, 1'b1);
        idle_s();
        repeat (2) @(negedge axis_aclk);
        chk("mid_rst_pre_valid", 64'(m00_axis.tvalid), 64'd1);
        axis_aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(m00_axis.tvalid), 64'd0);
        chk("mid_rst_fc", 64'(frame_count), 64'd0);
        chk("mid_rst_s_tready", 64'(s00_axis.tready), 64'd0);
        @(negedge axis_aclk);
        axis_aresetn    = 1'b1;
        m00_axis.tready = 1'b1;
        repeat (6) @(negedge axis_aclk);
        chk("mid_rst_no_output", 64'(rx_q.size()), 64'd0);
        chk("mid_rst_fc_after", 64'(frame_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
